// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Lookup is purely combinational; updates, flushes and statistics change on the rising clock edge.
module branch_predictor #(
    parameter int PC_WIDTH   = 32,
    parameter int ENTRIES    = 16,
    parameter int CTR_BITS   = 2,
    parameter int STAT_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic [PC_WIDTH-1:0]   pcF_i,
    output logic                  hit_o,
    output logic                  predict_taken_o,
    output logic [PC_WIDTH-1:0]   predict_target_o,

    input  logic                  update_en_i,
    input  logic [PC_WIDTH-1:0]   update_pc_i,
    input  logic                  update_taken_i,
    input  logic [PC_WIDTH-1:0]   update_target_i,
    input  logic                  update_mispredict_i,

    input  logic                  flush_i,
    input  logic                  stats_clr_i,
    output logic [STAT_WIDTH-1:0] branch_count_o,
    output logic [STAT_WIDTH-1:0] mispredict_count_o
);

    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = PC_WIDTH - IDX - 2;

    localparam logic [CTR_BITS-1:0]   CTR_MAX     = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0]   CTR_ZERO    = '0;
    localparam logic [CTR_BITS-1:0]   CTR_WEAK_T  = CTR_BITS'(1) << (CTR_BITS - 1);
    localparam logic [CTR_BITS-1:0]   CTR_WEAK_NT = CTR_WEAK_T - CTR_BITS'(1);
    localparam logic [STAT_WIDTH-1:0] STAT_MAX    = {STAT_WIDTH{1'b1}};

    logic                valid_q  [ENTRIES];
    logic [TAG_W-1:0]    tag_q    [ENTRIES];
    logic [PC_WIDTH-1:0] target_q [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q    [ENTRIES];

    logic [IDX-1:0]      f_idx;
    logic [TAG_W-1:0]    f_tag;
    logic [IDX-1:0]      u_idx;
    logic [TAG_W-1:0]    u_tag;
    logic                u_hit;

    logic                wr_en;
    logic [PC_WIDTH-1:0] wr_target;
    logic [CTR_BITS-1:0] wr_ctr;

    logic [STAT_WIDTH-1:0] branch_count_q;
    logic [STAT_WIDTH-1:0] mispredict_count_q;

    // Instruction alignment bits never select an entry.
    logic unused_align;
    assign unused_align = ^{pcF_i[1:0], update_pc_i[1:0]};

    assign f_idx = pcF_i[IDX+1:2];
    assign f_tag = pcF_i[PC_WIDTH-1:IDX+2];
    assign u_idx = update_pc_i[IDX+1:2];
    assign u_tag = update_pc_i[PC_WIDTH-1:IDX+2];

    // Lookup reads the registered table only, so a same-cycle update is not visible yet.
    always_comb begin
        hit_o            = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        predict_taken_o  = hit_o && ctr_q[f_idx][CTR_BITS-1];
        predict_target_o = pcF_i + PC_WIDTH'(4);
        if (predict_taken_o) begin
            predict_target_o = target_q[f_idx];
        end
    end

    // A not-taken miss never allocates; a not-taken hit keeps its old target.
    always_comb begin
        u_hit     = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
        wr_en     = update_en_i && (u_hit || update_taken_i);
        wr_target = update_taken_i ? update_target_i : target_q[u_idx];
        wr_ctr    = CTR_WEAK_T;
        if (u_hit) begin
            if (update_taken_i) begin
                wr_ctr = (ctr_q[u_idx] == CTR_MAX) ? CTR_MAX : ctr_q[u_idx] + CTR_BITS'(1);
            end else begin
                wr_ctr = (ctr_q[u_idx] == CTR_ZERO) ? CTR_ZERO : ctr_q[u_idx] - CTR_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WEAK_NT;
            end
        end else if (flush_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (wr_en) begin
            valid_q[u_idx]  <= 1'b1;
            tag_q[u_idx]    <= u_tag;
            target_q[u_idx] <= wr_target;
            ctr_q[u_idx]    <= wr_ctr;
        end
    end

    // Statistics ignore flush; clear wins over a same-cycle increment.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else if (stats_clr_i) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            if (update_en_i && (branch_count_q != STAT_MAX)) begin
                branch_count_q <= branch_count_q + STAT_WIDTH'(1);
            end
            if (update_en_i && update_mispredict_i && (mispredict_count_q != STAT_MAX)) begin
                mispredict_count_q <= mispredict_count_q + STAT_WIDTH'(1);
            end
        end
    end

    assign branch_count_o     = branch_count_q;
    assign mispredict_count_o = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: a vector table for lookup/update behaviour
// plus hand sequences for same-cycle lookup, statistics and asynchronous reset.
module tb_branch_predictor;

    logic        clk_i;
    logic        rst_ni;
    logic [31:0] pcF_i;
    logic        hit_o, predict_taken_o;
    logic [31:0] predict_target_o;
    logic        update_en_i, update_taken_i, update_mispredict_i;
    logic [31:0] update_pc_i, update_target_i;
    logic        flush_i, stats_clr_i;
    logic [15:0] branch_count_o, mispredict_count_o;

    logic        s_hit, s_taken;
    logic [31:0] s_target;
    logic [3:0]  s_branch_count, s_mispredict_count;

    int tests_run;
    int tests_failed;

    typedef struct {
        string       name;
        logic        upd;
        logic [31:0] upd_pc;
        logic        upd_taken;
        logic [31:0] upd_target;
        logic        flush;
        logic [31:0] look_pc;
        logic        exp_hit;
        logic        exp_taken;
        logic [31:0] exp_target;
    } vec_t;

    vec_t vecs[$];

    branch_predictor dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .pcF_i(pcF_i),
        .hit_o(hit_o), .predict_taken_o(predict_taken_o), .predict_target_o(predict_target_o),
        .update_en_i(update_en_i), .update_pc_i(update_pc_i), .update_taken_i(update_taken_i),
        .update_target_i(update_target_i), .update_mispredict_i(update_mispredict_i),
        .flush_i(flush_i), .stats_clr_i(stats_clr_i),
        .branch_count_o(branch_count_o), .mispredict_count_o(mispredict_count_o)
    );

    branch_predictor #(.STAT_WIDTH(4)) dut_small (
        .clk_i(clk_i), .rst_ni(rst_ni), .pcF_i(pcF_i),
        .hit_o(s_hit), .predict_taken_o(s_taken), .predict_target_o(s_target),
        .update_en_i(update_en_i), .update_pc_i(update_pc_i), .update_taken_i(update_taken_i),
        .update_target_i(update_target_i), .update_mispredict_i(update_mispredict_i),
        .flush_i(flush_i), .stats_clr_i(stats_clr_i),
        .branch_count_o(s_branch_count), .mispredict_count_o(s_mispredict_count)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic addVec(input string name, input logic upd, input logic [31:0] upd_pc,
                          input logic tk, input logic [31:0] tgt, input logic fl,
                          input logic [31:0] look, input logic eh, input logic et,
                          input logic [31:0] etgt);
        vec_t v;
        v.name = name; v.upd = upd; v.upd_pc = upd_pc; v.upd_taken = tk;
        v.upd_target = tgt; v.flush = fl; v.look_pc = look;
        v.exp_hit = eh; v.exp_taken = et; v.exp_target = etgt;
        vecs.push_back(v);
    endtask

    task automatic clearUpdate();
        update_en_i = 1'b0; update_taken_i = 1'b0; update_mispredict_i = 1'b0;
        update_pc_i = '0; update_target_i = '0; flush_i = 1'b0; stats_clr_i = 1'b0;
    endtask

    task automatic checkLookup(input string name, input logic eh, input logic et, input logic [31:0] etgt);
        checkOutput({name, " hit"}, {31'b0, hit_o}, {31'b0, eh});
        checkOutput({name, " taken"}, {31'b0, predict_taken_o}, {31'b0, et});
        checkOutput({name, " target"}, predict_target_o, etgt);
    endtask

    // Drives one vector through a clock edge, then presents its lookup PC.
    task automatic applyStimulus(input vec_t v);
        update_en_i     = v.upd;
        update_pc_i     = v.upd_pc;
        update_taken_i  = v.upd_taken;
        update_target_i = v.upd_target;
        flush_i         = v.flush;
        @(posedge clk_i);
        #1;
        clearUpdate();
        pcF_i = v.look_pc;
        #1;
        checkLookup(v.name, v.exp_hit, v.exp_taken, v.exp_target);
    endtask

    task automatic pulseUpdate(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic misp);
        update_en_i = 1'b1; update_pc_i = pc; update_taken_i = tk;
        update_target_i = tgt; update_mispredict_i = misp;
        @(posedge clk_i);
        #1;
        clearUpdate();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        addVec("alloc",       1, 32'h100, 1, 32'h80,  0, 32'h100, 1, 1, 32'h80);
        addVec("nt1 ctr1",    1, 32'h100, 0, 32'h0,   0, 32'h100, 1, 0, 32'h104);
        addVec("nt2 ctr0",    1, 32'h100, 0, 32'h0,   0, 32'h100, 1, 0, 32'h104);
        addVec("nt3 ctr0",    1, 32'h100, 0, 32'h0,   0, 32'h100, 1, 0, 32'h104);
        addVec("t1 ctr1",     1, 32'h100, 1, 32'h80,  0, 32'h100, 1, 0, 32'h104);
        addVec("t2 ctr2",     1, 32'h100, 1, 32'h80,  0, 32'h100, 1, 1, 32'h80);
        addVec("t3 ctr3",     1, 32'h100, 1, 32'h80,  0, 32'h100, 1, 1, 32'h80);
        addVec("t4 ctr3",     1, 32'h100, 1, 32'h80,  0, 32'h100, 1, 1, 32'h80);
        addVec("nt ctr2",     1, 32'h100, 0, 32'h0,   0, 32'h100, 1, 1, 32'h80);
        addVec("nt ctr1",     1, 32'h100, 0, 32'h0,   0, 32'h100, 1, 0, 32'h104);
        addVec("retarget",    1, 32'h100, 1, 32'h90,  0, 32'h100, 1, 1, 32'h90);
        addVec("t ctr3",      1, 32'h100, 1, 32'h90,  0, 32'h100, 1, 1, 32'h90);
        addVec("nt keep tgt", 1, 32'h100, 0, 32'hAA0, 0, 32'h100, 1, 1, 32'h90);
        addVec("alias miss",  0, 32'h0,   0, 32'h0,   0, 32'h140, 0, 0, 32'h144);
        addVec("nt miss",     1, 32'h140, 0, 32'h0,   0, 32'h140, 0, 0, 32'h144);
        addVec("nt miss keep",1, 32'h140, 0, 32'h0,   0, 32'h100, 1, 1, 32'h90);
        addVec("alias alloc", 1, 32'h140, 1, 32'h300, 0, 32'h140, 1, 1, 32'h300);
        addVec("old evicted", 0, 32'h0,   0, 32'h0,   0, 32'h100, 0, 0, 32'h104);
        addVec("low bits",    0, 32'h0,   0, 32'h0,   0, 32'h143, 1, 1, 32'h300);
        addVec("other idx",   1, 32'h104, 1, 32'h500, 0, 32'h104, 1, 1, 32'h500);
        addVec("flush+upd",   1, 32'h200, 1, 32'h400, 1, 32'h200, 0, 0, 32'h204);
        addVec("flush 104",   0, 32'h0,   0, 32'h0,   0, 32'h104, 0, 0, 32'h108);
        addVec("flush 140",   0, 32'h0,   0, 32'h0,   0, 32'h140, 0, 0, 32'h144);
        addVec("wrap pc+4",   0, 32'h0,   0, 32'h0,   0, 32'hFFFFFFFC, 0, 0, 32'h0);

        rst_ni = 1'b0;
        clearUpdate();
        pcF_i = 32'h100;
        #2;
        checkLookup("reset", 0, 0, 32'h104);
        checkOutput("reset branch_count", {16'b0, branch_count_o}, 32'd0);
        checkOutput("reset mispredict_count", {16'b0, mispredict_count_o}, 32'd0);

        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
        end

        // Same-cycle update and lookup at one index: lookup sees old contents.
        update_en_i = 1'b1; update_pc_i = 32'h300; update_taken_i = 1'b1; update_target_i = 32'h700;
        pcF_i = 32'h300;
        #1;
        checkLookup("no bypass", 0, 0, 32'h304);
        @(posedge clk_i);
        #1;
        clearUpdate();
        checkLookup("after bypass edge", 1, 1, 32'h700);

        // Statistics: five updates, two mispredicts, a flush in the middle.
        stats_clr_i = 1'b1;
        @(posedge clk_i);
        #1;
        clearUpdate();
        checkOutput("stats cleared", {16'b0, branch_count_o}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            update_en_i = 1'b1; update_pc_i = 32'h600; update_taken_i = 1'b0;
            update_mispredict_i = (i == 1 || i == 3);
            flush_i = (i == 2);
            @(posedge clk_i);
            #1;
        end
        clearUpdate();
        checkOutput("branch_count 5", {16'b0, branch_count_o}, 32'd5);
        checkOutput("mispredict_count 2", {16'b0, mispredict_count_o}, 32'd2);

        update_en_i = 1'b1; update_mispredict_i = 1'b1; stats_clr_i = 1'b1;
        @(posedge clk_i);
        #1;
        clearUpdate();
        checkOutput("clr beats inc branch", {16'b0, branch_count_o}, 32'd0);
        checkOutput("clr beats inc mispredict", {16'b0, mispredict_count_o}, 32'd0);

        for (int i = 0; i < 20; i++) begin
            pulseUpdate(32'h600, 1'b0, 32'h0, 1'b1);
        end
        checkOutput("branch_count 20", {16'b0, branch_count_o}, 32'd20);
        checkOutput("small branch_count sat", {28'b0, s_branch_count}, 32'd15);
        checkOutput("small mispredict_count sat", {28'b0, s_mispredict_count}, 32'd15);

        // Asynchronous reset mid-stream, with an update pending across an edge.
        pulseUpdate(32'h700, 1'b1, 32'h900, 1'b0);
        pcF_i = 32'h700;
        #1;
        checkLookup("pre-reset", 1, 1, 32'h900);
        rst_ni = 1'b0;
        update_en_i = 1'b1; update_pc_i = 32'h800; update_taken_i = 1'b1; update_target_i = 32'hA00;
        #1;
        checkLookup("async reset", 0, 0, 32'h704);
        checkOutput("async reset branch_count", {16'b0, branch_count_o}, 32'd0);
        checkOutput("async reset mispredict_count", {16'b0, mispredict_count_o}, 32'd0);
        @(posedge clk_i);
        #1;
        clearUpdate();
        @(negedge clk_i);
        rst_ni = 1'b1;
        pcF_i = 32'h800;
        #1;
        checkLookup("update discarded", 0, 0, 32'h804);
        update_en_i = 1'b1; update_pc_i = 32'h800; update_taken_i = 1'b1; update_target_i = 32'hA00;
        @(posedge clk_i);
        #1;
        clearUpdate();
        checkLookup("first edge after reset", 1, 1, 32'hA00);
        checkOutput("branch_count after reset", {16'b0, branch_count_o}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 32, the width of fetch and update PCs and targets.
REQ-002 SHALL have parameter ENTRIES, default 16, the number of table entries; it is a power of two and at least 2.
REQ-003 SHALL have parameter CTR_BITS, default 2, the width of each saturating direction counter, at least 1.
REQ-004 SHALL have parameter STAT_WIDTH, default 16, the width of the statistics counters.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port pcF_i, input, PC_WIDTH bits: the fetch-stage PC to look up.
REQ-008 SHALL have port hit_o, output, 1 bit: the lookup entry is valid and its tag matches.
REQ-009 SHALL have port predict_taken_o, output, 1 bit: the branch is predicted taken.
REQ-010 SHALL have port predict_target_o, output, PC_WIDTH bits: the predicted next fetch PC.
REQ-011 SHALL have port update_en_i, input, 1 bit: a resolved branch or jump is presented by the execute stage.
REQ-012 SHALL have port update_pc_i, input, PC_WIDTH bits: the PC of the resolved instruction (pcE).
REQ-013 SHALL have port update_taken_i, input, 1 bit: the resolved direction (pc_srcE).
REQ-014 SHALL have port update_target_i, input, PC_WIDTH bits: the resolved target (pcE + imm_extE).
REQ-015 SHALL have port update_mispredict_i, input, 1 bit: the execute stage flushed because of this instruction.
REQ-016 SHALL have port flush_i, input, 1 bit: invalidate all entries.
REQ-017 SHALL have port stats_clr_i, input, 1 bit: clear the statistics counters.
REQ-018 SHALL have port branch_count_o, output, STAT_WIDTH bits: the number of updates.
REQ-019 SHALL have port mispredict_count_o, output, STAT_WIDTH bits: the number of mispredicts.

Function
REQ-020 SHALL derive IDX = log2(ENTRIES) bits: index = pc[IDX+1:2] and tag = pc[PC_WIDTH-1:IDX+2]; PC bits [1:0] are ignored.
REQ-021 SHALL hold per entry a valid bit, a tag, a target of PC_WIDTH bits and a counter of CTR_BITS bits.
REQ-022 SHALL compute the lookup combinationally (zero latency): hit_o = valid && tag match; predict_taken_o = hit_o && counter MSB.
REQ-023 SHALL drive predict_target_o = stored target when predict_taken_o, else pcF_i + 4, with the addition modulo 2^PC_WIDTH.
REQ-024 SHALL, on an update hit with update_taken_i=1, increment the counter saturating at 2^CTR_BITS-1 and overwrite the target with update_target_i.
REQ-025 SHALL, on an update hit with update_taken_i=0, decrement the counter saturating at 0 and leave the target unchanged.
REQ-026 SHALL, on an update miss with update_taken_i=1, allocate the entry: valid=1, new tag, target=update_target_i, counter=2^(CTR_BITS-1) (weakly taken), replacing any aliasing entry.
REQ-027 SHALL, on an update miss with update_taken_i=0, leave the table unchanged.
REQ-028 SHALL, when an update and a lookup hit the same index in the same cycle, return the pre-update contents for the lookup (no bypass).
REQ-029 SHALL, on flush_i, clear all valid bits at the next edge and leave targets and counters unchanged; flush_i has priority over a same-cycle update, so no entry is valid afterwards.
REQ-030 SHALL increment branch_count_o on each cycle with update_en_i, and mispredict_count_o when update_en_i && update_mispredict_i; both saturate at all-ones and flush_i does not affect them.
REQ-031 SHALL, on stats_clr_i, zero both statistics counters; stats_clr_i has priority over a same-cycle increment.

Reset
REQ-032 SHALL, while rst_ni is low, immediately and without a clock set: all valid bits 0, counters 2^(CTR_BITS-1)-1 (weakly not-taken), targets 0, statistics 0.
REQ-033 SHALL, after reset, drive hit_o=0, predict_taken_o=0 and predict_target_o=pcF_i+4.
REQ-034 SHALL, if reset is asserted mid-operation, discard any same-cycle update; the first edge after rst_ni rises is a normal operating edge.

Verification (defaults, except where noted)
REQ-035 Reset, pcF_i=0x100 -> hit_o=0, predict_taken_o=0, predict_target_o=0x104.
REQ-036 One update at pc 0x100, taken, target 0x80; then pcF_i=0x100 -> hit_o=1, predict_taken_o=1, predict_target_o=0x80, counter=2.
REQ-037 Counter saturation at pc 0x100:
- three not-taken updates -> counter 1, 0, 0; predict_taken_o=0, predict_target_o=0x104, hit_o=1;
- then four taken updates -> counter 3, stays 3.
REQ-038 Aliasing: with 0x100 allocated, lookup 0x140 (same index, different tag) -> hit_o=0; a taken update at 0x140 -> 0x140 hits and 0x100 misses.
REQ-039 flush_i and a taken update at 0x200 in the same cycle -> lookups at 0x100 and 0x200 both give hit_o=0.
REQ-040 Statistics:
- 5 updates, 2 with update_mispredict_i -> branch_count_o=5, mispredict_count_o=2;
- with STAT_WIDTH=4, 20 updates -> branch_count_o=15;
- stats_clr_i together with update_en_i -> branch_count_o=0;
- rst_ni low mid-stream, with no clock edge -> all outputs return to their reset values.
